// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file: state encoding,
// default geometry, and the address-width helper used by decode/writeback.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    localparam int unsigned RF_XLEN_DEF  = 32;
    localparam int unsigned RF_NREGS_DEF = 32;

    // A single-entry file still needs one address bit.
    function automatic int unsigned rf_aw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Reset-triggered clear sequencer: sweeps every entry to zero once after
// reset release, then holds RUN and advertises write readiness.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = RF_NREGS_DEF,
    parameter int unsigned AW    = rf_aw(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output rf_state_e     state_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          init_done_o,
    output logic          wr_ready_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          init_done_q, init_done_d;
    logic          wr_ready_q, wr_ready_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clr_idx_q   <= '0;
            init_done_q <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            init_done_q <= init_done_d;
            wr_ready_q  <= wr_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        init_done_d = init_done_q;
        wr_ready_d  = wr_ready_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                    wr_ready_d  = 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // The storage must stay untouched while reset is asserted.
    assign clr_we_o    = (state_q == CLEAR) && rst_n;
    assign clr_addr_o  = clr_idx_q;
    assign state_o     = state_q;
    assign init_done_o = init_done_q;
    assign wr_ready_o  = wr_ready_q;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: one write port, NRD combinational read ports,
// hardwired x0, optional write-to-read bypass, and a post-reset clear sweep.
module regfile_multiport
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = RF_XLEN_DEF,
    parameter int unsigned NREGS  = RF_NREGS_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [rf_aw(NREGS)-1:0]      waddr,
    input  logic [XLEN-1:0]              wdata,
    output logic                         wr_ready,
    input  logic [NRD*rf_aw(NREGS)-1:0]  raddr,
    output logic [NRD*XLEN-1:0]          rdata,
    output logic                         init_done
);

    localparam int unsigned   AW      = rf_aw(NREGS);
    localparam logic [AW:0]   NREGS_L = NREGS[AW:0];

    logic [XLEN-1:0] mem_q [NREGS];

    rf_state_e     state;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          run_we;

    rf_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .state_o     (state),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr),
        .init_done_o (init_done),
        .wr_ready_o  (wr_ready)
    );

    // Address 0 and addresses past the last register never touch storage.
    assign run_we = wr_ready && we && (waddr != '0) && ({1'b0, waddr} < NREGS_L);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (run_we) begin
            mem_q[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = raddr[i*AW +: AW];

        always_comb begin
            rd = '0;
            if ((state == RUN) && (ra != '0) && ({1'b0, ra} < NREGS_L)) begin
                if ((BYPASS != 0) && we && (waddr == ra)) begin
                    rd = wdata;
                end else begin
                    rd = mem_q[ra];
                end
            end
        end

        assign rdata[i*XLEN +: XLEN] = rd;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default config, a BYPASS=0 copy and a
// 24-entry / 3-read-port copy, all sharing one clock.
module tb_regfile_multiport;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: XLEN=32, NREGS=32, NRD=2, BYPASS=1
    logic        rst_n_a, we_a, wr_ready_a, init_done_a;
    logic [4:0]  waddr_a;
    logic [31:0] wdata_a;
    logic [9:0]  raddr_a;
    logic [63:0] rdata_a;

    // Instance B: same geometry, BYPASS=0
    logic        rst_n_b, we_b, wr_ready_b, init_done_b;
    logic [4:0]  waddr_b;
    logic [31:0] wdata_b;
    logic [9:0]  raddr_b;
    logic [63:0] rdata_b;

    // Instance C: NREGS=24, NRD=3
    logic        rst_n_c, we_c, wr_ready_c, init_done_c;
    logic [4:0]  waddr_c;
    logic [31:0] wdata_c;
    logic [14:0] raddr_c;
    logic [95:0] rdata_c;

    regfile_multiport #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_a (
        .clk(clk), .rst_n(rst_n_a), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .wr_ready(wr_ready_a), .raddr(raddr_a), .rdata(rdata_a), .init_done(init_done_a)
    );

    regfile_multiport #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n_b), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .wr_ready(wr_ready_b), .raddr(raddr_b), .rdata(rdata_b), .init_done(init_done_b)
    );

    regfile_multiport #(.XLEN(32), .NREGS(24), .NRD(3), .BYPASS(1)) u_c (
        .clk(clk), .rst_n(rst_n_c), .we(we_c), .waddr(waddr_c), .wdata(wdata_c),
        .wr_ready(wr_ready_c), .raddr(raddr_c), .rdata(rdata_c), .init_done(init_done_c)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return init_done_a;
            1:       return init_done_b;
            default: return init_done_c;
        endcase
    endfunction

    // Counts posedges after release until init_done is seen; -1 if never.
    task automatic wait_done(input int sel, input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (get_done(sel)) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int k;

        rst_n_a = 1'b0; we_a = 1'b0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
        rst_n_b = 1'b0; we_b = 1'b0; waddr_b = '0; wdata_b = '0; raddr_b = '0;
        rst_n_c = 1'b0; we_c = 1'b0; waddr_c = '0; wdata_c = '0; raddr_c = '0;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4] = '{1'b1, 5'd7,  32'h00001234, 5'd7,  5'd6,  32'h00001234, 32'h0};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,  32'h00001234, 32'h00001234};
        vecs[6] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd7,  32'hA5A5A5A5, 32'h00001234};
        vecs[7] = '{1'b1, 5'd7,  32'hCAFEF00D, 5'd7,  5'd31, 32'hCAFEF00D, 32'hA5A5A5A5};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd1,  32'hCAFEF00D, 32'h0};
        vecs[9] = '{1'b1, 5'd1,  32'h00000001, 5'd2,  5'd1,  32'h0,        32'h00000001};

        // ---- A: reset sweep ----
        repeat (3) @(negedge clk);
        chk("a_reset_init_done", {31'b0, init_done_a}, 32'h0);
        chk("a_reset_wr_ready", {31'b0, wr_ready_a}, 32'h0);
        chk("a_reset_rdata0", rdata_a[31:0], 32'h0);
        rst_n_a = 1'b1;
        for (k = 1; k <= 33; k++) begin
            @(negedge clk);
            chk($sformatf("a_sweep_init_done_c%0d", k), {31'b0, init_done_a}, {31'b0, (k >= 32)});
            chk($sformatf("a_sweep_wr_ready_c%0d", k), {31'b0, wr_ready_a}, {31'b0, (k >= 32)});
        end
        for (int a = 0; a < 32; a++) begin
            raddr_a = {5'(a), 5'(a)};
            #1;
            chk($sformatf("a_cleared_p0_x%0d", a), rdata_a[31:0], 32'h0);
            chk($sformatf("a_cleared_p1_x%0d", a), rdata_a[63:32], 32'h0);
        end

        // ---- A: table-driven write/read vectors ----
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            we_a = vecs[i].we; waddr_a = vecs[i].wa; wdata_a = vecs[i].wd;
            raddr_a = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("a_vec%0d_rd0", i), rdata_a[31:0], vecs[i].e0);
            chk($sformatf("a_vec%0d_rd1", i), rdata_a[63:32], vecs[i].e1);
        end
        @(negedge clk);
        we_a = 1'b0;

        // ---- A: write issued during the clear sweep is dropped ----
        rst_n_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_a = 1'b1;
        raddr_a = {5'd3, 5'd31};
        cyc = -1;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) chk("a_clear_rdata_x31", rdata_a[31:0], 32'h0);
            if (k == 5) begin
                we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h000000AA;
                #1;
                chk("a_clear_bypass_x3", rdata_a[63:32], 32'h0);
            end
            if (k == 6) we_a = 1'b0;
            if (init_done_a) begin
                cyc = k;
                break;
            end
        end
        chk("a_resweep_len", cyc, 32);
        #1;
        chk("a_after_clear_x3", rdata_a[63:32], 32'h0);
        chk("a_after_clear_x31", rdata_a[31:0], 32'h0);
        raddr_a = {5'd5, 5'd7};
        #1;
        chk("a_after_clear_x7", rdata_a[31:0], 32'h0);
        chk("a_after_clear_x5", rdata_a[63:32], 32'h0);

        // ---- B: BYPASS=0 sees only stored contents ----
        rst_n_b = 1'b1;
        wait_done(1, 40, cyc);
        chk("b_sweep_len", cyc, 32);
        we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h00001111; raddr_b = {5'd7, 5'd7};
        #1;
        chk("b_nobypass_first_rd0", rdata_b[31:0], 32'h0);
        chk("b_nobypass_first_rd1", rdata_b[63:32], 32'h0);
        @(negedge clk);
        wdata_b = 32'h00001234;
        #1;
        chk("b_nobypass_old_rd0", rdata_b[31:0], 32'h00001111);
        @(negedge clk);
        we_b = 1'b0;
        #1;
        chk("b_next_cycle_rd0", rdata_b[31:0], 32'h00001234);
        chk("b_next_cycle_rd1", rdata_b[63:32], 32'h00001234);

        // ---- C: mid-sweep reset restarts the sweep ----
        rst_n_c = 1'b1;
        repeat (10) @(negedge clk);
        chk("c_midsweep_not_done", {31'b0, init_done_c}, 32'h0);
        rst_n_c = 1'b0;
        @(negedge clk);
        chk("c_pulse_not_done", {31'b0, init_done_c}, 32'h0);
        rst_n_c = 1'b1;
        wait_done(2, 40, cyc);
        chk("c_sweep_len_after_pulse", cyc, 24);
        chk("c_wr_ready", {31'b0, wr_ready_c}, 32'h1);

        // ---- C: out-of-range address, last valid address ----
        we_c = 1'b1; waddr_c = 5'd30; wdata_c = 32'h0000BEEF;
        raddr_c = {5'd30, 5'd30, 5'd30};
        #1;
        chk("c_oor_bypass_rd0", rdata_c[31:0], 32'h0);
        chk("c_oor_bypass_rd2", rdata_c[95:64], 32'h0);
        @(negedge clk);
        waddr_c = 5'd23; wdata_c = 32'h00000055;
        raddr_c = {5'd14, 5'd23, 5'd30};
        #1;
        chk("c_oor_read30", rdata_c[31:0], 32'h0);
        chk("c_last_bypass_rd1", rdata_c[63:32], 32'h00000055);
        chk("c_alias14", rdata_c[95:64], 32'h0);
        @(negedge clk);
        we_c = 1'b0;
        raddr_c = {5'd6, 5'd0, 5'd23};
        #1;
        chk("c_last_stored_rd0", rdata_c[31:0], 32'h00000055);
        chk("c_x0_rd1", rdata_c[63:32], 32'h0);
        chk("c_alias6", rdata_c[95:64], 32'h0);
        raddr_c = {5'd23, 5'd23, 5'd30};
        #1;
        chk("c_same_addr_rd1", rdata_c[63:32], 32'h00000055);
        chk("c_same_addr_rd2", rdata_c[95:64], 32'h00000055);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
